// File: rtl/spimemio_arbiter.sv
`timescale 1ns/1ps
// Shares the SPI flash read port between instruction fetch (m0) and data read (m1),
// serialises config-register writes between reads, and aborts reads that never complete.
module spimemio_arbiter #(
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned CW = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic [23:0] m0_addr,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_valid,
  input  logic [23:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  input  logic [3:0]  cfg_we,
  input  logic [31:0] cfg_di,
  output logic        cfg_ready,
  output logic [31:0] cfg_do,

  output logic        mem_valid,
  output logic [23:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic [3:0]  cfgreg_we,
  output logic [31:0] cfgreg_di,
  input  logic [31:0] cfgreg_do
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StCfg} state_e;

  localparam logic [CW-1:0] LastCount = CW'(TIMEOUT - 1);

  state_e        state;
  logic          prio;
  logic          gnt;
  logic          gnt_next;
  logic [CW-1:0] counter;

  assign cfg_do = cfgreg_do;

  // Single requester wins outright; on contention the one named by prio wins.
  always_comb begin
    gnt_next = m1_valid;
    if (m0_valid && m1_valid) begin
      gnt_next = prio;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      prio      <= 1'b0;
      gnt       <= 1'b0;
      counter   <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      m0_ready  <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_ready  <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
      cfg_ready <= 1'b0;
      cfgreg_we <= '0;
      cfgreg_di <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          cfg_ready <= 1'b0;
          cfgreg_we <= '0;
          // cfg_we is still held while cfg_ready is visible; don't issue it twice.
          if ((cfg_we != 4'b0000) && !cfg_ready) begin
            state <= StCfg;
          end else if (m0_valid || m1_valid) begin
            gnt       <= gnt_next;
            mem_addr  <= gnt_next ? m1_addr : m0_addr;
            mem_valid <= 1'b1;
            counter   <= '0;
            state     <= StBusy;
          end
        end

        StBusy: begin
          if (mem_ready) begin
            if (gnt) begin
              m1_rdata <= mem_rdata;
              m1_ready <= 1'b1;
              m1_err   <= 1'b0;
            end else begin
              m0_rdata <= mem_rdata;
              m0_ready <= 1'b1;
              m0_err   <= 1'b0;
            end
            mem_valid <= 1'b0;
            state     <= StResp;
          end else if (counter == LastCount) begin
            if (gnt) begin
              m1_rdata <= 32'hFFFF_FFFF;
              m1_ready <= 1'b1;
              m1_err   <= 1'b1;
            end else begin
              m0_rdata <= 32'hFFFF_FFFF;
              m0_ready <= 1'b1;
              m0_err   <= 1'b1;
            end
            mem_valid <= 1'b0;
            state     <= StResp;
          end else begin
            counter <= counter + 1'b1;
          end
        end

        StResp: begin
          m0_ready <= 1'b0;
          m0_err   <= 1'b0;
          m1_ready <= 1'b0;
          m1_err   <= 1'b0;
          prio     <= ~gnt;
          state    <= StIdle;
        end

        StCfg: begin
          cfgreg_we <= cfg_we;
          cfgreg_di <= cfg_di;
          cfg_ready <= 1'b1;
          state     <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spimemio_arbiter.sv
`timescale 1ns/1ps
// Bench for spimemio_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level model of arbitration, controller latency and the watchdog.
module tb_spimemio_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid, m1_valid, m0_ready, m1_ready, m0_err, m1_err;
  logic [23:0] m0_addr, m1_addr, mem_addr;
  logic [31:0] m0_rdata, m1_rdata, cfg_di, cfg_do, mem_rdata, cfgreg_di, cfgreg_do;
  logic [3:0]  cfg_we, cfgreg_we;
  logic        cfg_ready, mem_valid, mem_ready;

  int total = 0;
  int bad = 0;
  int m1_pulses = 0;
  int cfg_pulses = 0;

  spimemio_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_ready(m0_ready),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_ready(m1_ready),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .cfg_we(cfg_we), .cfg_di(cfg_di), .cfg_ready(cfg_ready), .cfg_do(cfg_do),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .cfgreg_we(cfgreg_we), .cfgreg_di(cfgreg_di), .cfgreg_do(cfgreg_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m1_ready === 1'b1) m1_pulses++;
    if (cfg_ready === 1'b1) cfg_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1;
    m0_valid = 1'b0; m1_valid = 1'b0; m0_addr = '0; m1_addr = '0;
    cfg_we = '0; cfg_di = '0; mem_ready = 1'b0; mem_rdata = '0; cfgreg_do = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Acts as the flash controller for one read: answers d cycles after mem_valid is seen.
  task automatic serve(input int d, input logic [31:0] data, output logic [23:0] addr,
                       output logic [1:0] rdy, output bit seen);
    seen = 1'b0; rdy = '0; addr = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_valid === 1'b1) seen = 1'b1;
    end
    if (seen) begin
      addr = mem_addr;
      repeat (d) @(negedge clk);
      mem_ready = 1'b1; mem_rdata = data;
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = $urandom;
      rdy = {m1_ready, m0_ready};
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_valid = 1'b1; m1_valid = 1'b1; cfg_we = 4'hF; cfg_di = 32'hA5A5_A5A5;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678; cfgreg_do = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_valid, mem_addr, m0_ready, m0_rdata, m0_err, m1_ready, m1_rdata, m1_err,
         cfg_ready, cfgreg_we, cfgreg_di} !== '0) begin
      bad++; $display("FAIL reset_outputs got mem_valid=%b cfgreg_we=%h m0_ready=%b exp all 0",
                      mem_valid, cfgreg_we, m0_ready);
    end
    total++;
    if (cfg_do !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL reset_cfg_do got=%h exp=%h", cfg_do, 32'h0BAD_F00D);
    end
    do_reset();
    @(negedge clk);
    total++;
    if ({mem_valid, cfg_ready, cfgreg_we, m0_ready, m1_ready} !== '0) begin
      bad++; $display("FAIL reset_idle got mem_valid=%b cfg_ready=%b exp 0", mem_valid, cfg_ready);
    end
  endtask

  task automatic test_single();
    logic [23:0] a; logic [1:0] r; bit s; int p1;
    do_reset();
    p1 = m1_pulses;
    m0_addr = 24'h000100; m0_valid = 1'b1;
    serve(5, 32'hDEADBEEF, a, r, s);
    total++;
    if (!s || a !== 24'h000100) begin
      bad++; $display("FAIL single_addr got=%h seen=%0d exp=%h", a, s, 24'h000100);
    end
    total++;
    if (r !== 2'b01 || m0_rdata !== 32'hDEADBEEF || m0_err !== 1'b0) begin
      bad++; $display("FAIL single_resp got rdy=%b data=%h err=%b exp rdy=01 data=deadbeef err=0",
                      r, m0_rdata, m0_err);
    end
    m0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (m0_ready !== 1'b0) begin
      bad++; $display("FAIL single_pulse got m0_ready=%b exp=0", m0_ready);
    end
    repeat (3) @(negedge clk);
    total++;
    if (m1_pulses !== p1 || m0_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_hold got m1_pulses=%0d data=%h exp m1_pulses=%0d data=deadbeef",
                      m1_pulses, m0_rdata, p1);
    end
  endtask

  task automatic test_both();
    logic [23:0] a; logic [1:0] r; bit s; logic [1:0] exp_r;
    do_reset();
    m0_addr = 24'h10; m1_addr = 24'h20; m0_valid = 1'b1; m1_valid = 1'b1;
    serve(2, 32'h1111_0000, a, r, s);
    total++;
    if (!s || a !== 24'h10 || r !== 2'b01) begin
      bad++; $display("FAIL both_first got addr=%h rdy=%b exp addr=10 rdy=01", a, r);
    end
    m0_valid = 1'b0;
    serve(2, 32'h2222_0000, a, r, s);
    total++;
    if (!s || a !== 24'h20 || r !== 2'b10 || m1_rdata !== 32'h2222_0000) begin
      bad++; $display("FAIL both_second got addr=%h rdy=%b data=%h exp addr=20 rdy=10 data=22220000",
                      a, r, m1_rdata);
    end
    m1_valid = 1'b0;
    @(negedge clk);
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
      serve(1, $urandom, a, r, s);
      total++;
      if (!s || r !== exp_r || a !== (exp_r[1] ? 24'h20 : 24'h10)) begin
        bad++; $display("FAIL both_alt%0d got rdy=%b addr=%h exp rdy=%b", i, r, a, exp_r);
      end
      if (r[0]) m0_valid = 1'b0; else m1_valid = 1'b0;
      @(negedge clk);
      m0_valid = 1'b1; m1_valid = 1'b1;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  task automatic test_cfg_during_busy();
    bit seen; int viol; int k; int p0; logic [31:0] rb;
    do_reset();
    m1_addr = 24'h30; m1_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_valid === 1'b1) seen = 1'b1;
    end
    cfg_we = 4'b1000; cfg_di = 32'h8000_0000;
    viol = 0;
    repeat (3) begin
      @(negedge clk);
      if (cfgreg_we !== 4'b0000 || cfg_ready !== 1'b0) viol++;
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    mem_ready = 1'b0;
    total++;
    if (!seen || m1_ready !== 1'b1 || m1_rdata !== 32'hCAFE_0001 || viol != 0 ||
        cfgreg_we !== 4'b0000) begin
      bad++; $display("FAIL cfg_wait got m1_ready=%b viol=%0d cfgreg_we=%h exp 1/0/0",
                      m1_ready, viol, cfgreg_we);
    end
    m1_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      @(negedge clk);
      if (cfg_ready === 1'b1) k = i;
    end
    total++;
    if (k != 3) begin
      bad++; $display("FAIL cfg_latency got=%0d exp=3", k);
    end
    total++;
    if (cfgreg_we !== 4'b1000 || cfgreg_di !== 32'h8000_0000 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL cfg_issue got we=%h di=%h mem_valid=%b exp we=8 di=80000000 mv=0",
                      cfgreg_we, cfgreg_di, mem_valid);
    end
    @(negedge clk);
    cfg_we = '0; cfg_di = '0;
    p0 = cfg_pulses;
    repeat (5) @(negedge clk);
    total++;
    if (cfg_pulses !== p0 || cfgreg_we !== 4'b0000) begin
      bad++; $display("FAIL cfg_single got pulses=%0d we=%h exp pulses=%0d we=0",
                      cfg_pulses, cfgreg_we, p0);
    end
    rb = $urandom; cfgreg_do = rb;
    #1;
    total++;
    if (cfg_do !== rb) begin
      bad++; $display("FAIL cfg_do got=%h exp=%h", cfg_do, rb);
    end
  endtask

  task automatic test_timeout();
    logic [23:0] a; logic [1:0] r; bit s; int hi; logic [31:0] data;
    do_reset();
    m0_addr = 24'($urandom); m0_valid = 1'b1;
    s = 1'b0;
    for (int i = 0; i < 20 && !s; i++) begin
      @(negedge clk);
      if (mem_valid === 1'b1) s = 1'b1;
    end
    hi = 0;
    while (mem_valid === 1'b1 && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    total++;
    if (hi != T) begin
      bad++; $display("FAIL timeout_len got=%0d exp=%0d", hi, T);
    end
    total++;
    if (m0_ready !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL timeout_resp got rdy=%b err=%b data=%h exp 1/1/ffffffff",
                      m0_ready, m0_err, m0_rdata);
    end
    m0_valid = 1'b0;
    @(negedge clk);
    data = $urandom;
    m0_addr = 24'h00_0200; m0_valid = 1'b1;
    serve(2, data, a, r, s);
    total++;
    if (r !== 2'b01 || m0_err !== 1'b0 || m0_rdata !== data || a !== 24'h00_0200) begin
      bad++; $display("FAIL timeout_after got rdy=%b err=%b data=%h exp rdy=01 err=0 data=%h",
                      r, m0_err, m0_rdata, data);
    end
    m0_valid = 1'b0;

    // Controller answers on the very last allowed cycle: data must win over the abort.
    @(negedge clk);
    m0_valid = 1'b1;
    serve(T - 1, 32'h1234_5678, a, r, s);
    total++;
    if (r !== 2'b01 || m0_err !== 1'b0 || m0_rdata !== 32'h1234_5678) begin
      bad++; $display("FAIL timeout_race got rdy=%b err=%b data=%h exp rdy=01 err=0 data=12345678",
                      r, m0_err, m0_rdata);
    end
    m0_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [23:0] a; logic [1:0] r; bit s; int p1;
    do_reset();
    m0_addr = 24'h50; m0_valid = 1'b1;
    serve(1, 32'h5555_5555, a, r, s);
    m0_valid = 1'b0;
    @(negedge clk);
    m1_addr = 24'h40; m1_valid = 1'b1;
    s = 1'b0;
    for (int i = 0; i < 20 && !s; i++) begin
      @(negedge clk);
      if (mem_valid === 1'b1) s = 1'b1;
    end
    p1 = m1_pulses;
    #2 reset = 1'b1;
    #1;
    total++;
    if (!s || mem_valid !== 1'b0 || m1_ready !== 1'b0 || cfgreg_we !== 4'b0000) begin
      bad++; $display("FAIL reset_mid got seen=%0d mem_valid=%b m1_ready=%b exp seen=1 0 0",
                      s, mem_valid, m1_ready);
    end
    m1_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m0_addr = 24'h60; m1_addr = 24'h70; m0_valid = 1'b1; m1_valid = 1'b1;
    serve(1, 32'h6666_6666, a, r, s);
    total++;
    if (r !== 2'b01 || a !== 24'h60 || m1_pulses !== p1) begin
      bad++; $display("FAIL reset_prio got rdy=%b addr=%h m1_pulses=%0d exp rdy=01 addr=60 %0d",
                      r, a, m1_pulses, p1);
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  // Model: idle -> grant (prio decides on contention) -> controller latency d, aborted at
  // T cycles -> one response cycle -> idle. After serving g, the other requester has priority.
  task automatic test_random();
    bit idle, dec, resp_prev, ctl_act, exp_resp, pv0, pv1, mprio, mgnt, exp_err;
    int ctl_cnt, d, zeros, nresp;
    logic [31:0] cdata, exp_data;
    logic [23:0] a0, a1, gaddr;
    do_reset();
    idle = 1; dec = 0; resp_prev = 0; ctl_act = 0; exp_resp = 0; pv0 = 0; pv1 = 0;
    mprio = 0; mgnt = 0; exp_err = 0; ctl_cnt = 0; d = 0; zeros = 2; nresp = 0;
    cdata = '0; exp_data = '0; a0 = '0; a1 = '0; gaddr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r0, r1, resp;
      @(negedge clk);
      r0 = m0_ready; r1 = m1_ready; resp = r0 | r1;
      if (dec) begin
        if (pv0 || pv1) begin
          mgnt = (pv0 && pv1) ? mprio : pv1;
          gaddr = mgnt ? a1 : a0;
          total++;
          if (mem_valid !== 1'b1 || mem_addr !== gaddr || zeros < 2) begin
            bad++; $display("FAIL rand_grant cyc=%0d got mv=%b addr=%h gap=%0d exp mv=1 addr=%h",
                            cyc, mem_valid, mem_addr, zeros, gaddr);
          end
          idle = 0;
        end else begin
          idle = 1;
        end
      end else if (resp_prev) begin
        idle = 1;
      end
      if (idle) begin
        total++;
        if (mem_valid !== 1'b0 || resp) begin
          bad++; $display("FAIL rand_idle cyc=%0d got mv=%b rdy=%b%b exp 0", cyc, mem_valid, r1, r0);
        end
      end else begin
        total++;
        if (resp !== exp_resp) begin
          bad++; $display("FAIL rand_resp_time cyc=%0d got=%b exp=%b", cyc, resp, exp_resp);
        end
        if (resp) begin
          nresp++;
          total++;
          if ({r1, r0} !== (mgnt ? 2'b10 : 2'b01) || mem_valid !== 1'b0 ||
              (mgnt ? m1_rdata : m0_rdata) !== exp_data || (mgnt ? m1_err : m0_err) !== exp_err) begin
            bad++; $display("FAIL rand_resp cyc=%0d got rdy=%b%b d0=%h d1=%h e=%b%b exp g=%0d d=%h e=%b",
                            cyc, r1, r0, m0_rdata, m1_rdata, m1_err, m0_err, mgnt, exp_data, exp_err);
          end
          mprio = !mgnt;
        end else begin
          total++;
          if (mem_valid !== 1'b1 || mem_addr !== gaddr) begin
            bad++; $display("FAIL rand_busy cyc=%0d got mv=%b addr=%h exp mv=1 addr=%h",
                            cyc, mem_valid, mem_addr, gaddr);
          end
        end
      end
      if (mem_valid === 1'b1) begin
        if (!ctl_act) begin
          ctl_act = 1; ctl_cnt = 0; d = $urandom_range(0, 10); cdata = $urandom;
        end else begin
          ctl_cnt++;
        end
        exp_resp = (ctl_cnt == d) || (ctl_cnt == T - 1);
        exp_err = (d >= T);
        exp_data = exp_err ? 32'hFFFF_FFFF : cdata;
        mem_ready = (ctl_cnt == d);
        mem_rdata = mem_ready ? cdata : $urandom;
      end else begin
        ctl_act = 0; mem_ready = 1'b0; exp_resp = 0;
      end
      if (r0) m0_valid = 1'b0;
      else if (!m0_valid && $urandom_range(0, 2) != 0) begin
        m0_valid = 1'b1; m0_addr = 24'($urandom);
      end
      if (r1) m1_valid = 1'b0;
      else if (!m1_valid && $urandom_range(0, 2) != 0) begin
        m1_valid = 1'b1; m1_addr = 24'($urandom);
      end
      pv0 = m0_valid; pv1 = m1_valid; a0 = m0_addr; a1 = m1_addr;
      dec = idle; resp_prev = resp;
      if (mem_valid === 1'b1) zeros = 0; else zeros++;
    end
    total++;
    if (nresp < 50) begin
      bad++; $display("FAIL rand_progress got=%0d exp>=50", nresp);
    end
    do_reset();
  endtask

  initial begin
    m0_valid = 1'b0; m1_valid = 1'b0; m0_addr = '0; m1_addr = '0;
    cfg_we = '0; cfg_di = '0; mem_ready = 1'b0; mem_rdata = '0; cfgreg_do = '0;
    test_reset();
    test_single();
    test_both();
    test_cfg_during_busy();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spimemio_arbiter.md
Name: spimemio_arbiter

Overview:
- Shares the single SPI flash memory-read port between two requesters: m0 (instruction fetch) and m1 (data read).
- Sequences configuration-register writes so they reach the flash controller only while no read is in flight.
- Sits between the CPU bus decode and the flash controller.
- Adds a watchdog that aborts a read the controller never completes and returns an error to the requester.

Parameters:
TIMEOUT, 1024, max cycles in BUSY before abort; legal range 2..65535
CW, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
m0_valid  in  1  requester 0 read request, held until m0_ready
m0_addr  in  24  requester 0 byte address
m0_ready  out  1  one-cycle pulse: m0_rdata/m0_err valid
m0_rdata  out  32  requester 0 read data
m0_err  out  1  qualifies m0_ready: 1 = timeout abort
m1_valid, m1_addr, m1_ready, m1_rdata, m1_err  as m0, for requester 1
cfg_we  in  4  byte-lane config write strobes, held until cfg_ready
cfg_di  in  32  config write data
cfg_ready  out  1  one-cycle pulse: config write issued
cfg_do  out  32  config readback, combinational copy of cfgreg_do
mem_valid  out  1  to flash controller: read request
mem_addr  out  24  to flash controller: address
mem_ready  in  1  from flash controller: mem_rdata valid
mem_rdata  in  32  from flash controller
cfgreg_we  out  4  to flash controller: config strobes
cfgreg_di  out  32  to flash controller: config data
cfgreg_do  in  32  from flash controller: config readback

Behaviour:
- All outputs are registered except cfg_do.
- Reset values: every output 0; prio=0; state=IDLE; counter=0.
- States: IDLE, BUSY, RESP, CFG.
- IDLE arbitration, in priority order:
  - cfg_we!=0 → CFG. Config has absolute priority over reads.
  - Only one mX_valid → grant that requester.
  - Both valid → grant m[prio].
  - On grant: latch grant index; mem_addr<=mX_addr; mem_valid<=1; counter<=0; → BUSY. mem_valid is high in the cycle after the grant decision.
- BUSY: mem_valid and mem_addr held stable; counter increments each cycle.
  - mem_ready=1: mX_rdata<=mem_rdata; mX_ready<=1; mX_err<=0; mem_valid<=0; → RESP.
  - Else if counter==TIMEOUT-1: mX_rdata<=32'hFFFF_FFFF; mX_ready<=1; mX_err<=1; mem_valid<=0; → RESP.
  - mem_ready wins if it coincides with the timeout cycle.
- RESP: the ready pulse is visible for exactly this one cycle. Next state clears mX_ready and mX_err; prio <= !granted index; → IDLE. Requesters drop valid on the edge ending RESP, so IDLE never re-grants a completed request. mX_rdata holds its value until that requester's next completion.
- CFG (single cycle, entered from IDLE): cfgreg_we<=cfg_we; cfgreg_di<=cfg_di; cfg_ready<=1; → IDLE. In the following cycle cfgreg_we<=0 and cfg_ready<=0.
  - cfgreg_we is therefore high for exactly one cycle and never overlaps mem_valid=1.
  - A config write arriving during BUSY waits until the read completes.
- Never more than one mem_valid transaction in flight; mem_valid never rises in the cycle directly after RESP.
- Starvation bound: a requester held valid is served within two read transactions plus pending config writes.
- Reset asserted mid-operation: mem_valid, cfgreg_we and all ready pulses drop immediately (asynchronous); the in-flight read is discarded with no response.

Test Plan:
- m0 alone, addr 0x000100, controller gives mem_ready 5 cycles after mem_valid with rdata 0xDEADBEEF → m0_ready one pulse, m0_rdata=0xDEADBEEF, m0_err=0, m1_ready never asserts.
- m0 and m1 valid in the same cycle after reset, addr 0x10 and 0x20 → m0 served first, then m1; mem_addr sequence 0x10, 0x20; then with both held, grants alternate m0,m1,m0,m1.
- cfg_we=4'b1000, cfg_di=0x80000000 raised while an m1 read is BUSY → cfgreg_we stays 0 until after m1_ready; then a single cycle with cfgreg_we=4'b1000, cfgreg_di=0x80000000, cfg_ready=1, mem_valid=0.
- TIMEOUT=8, mem_ready held 0 → mem_valid high for exactly 8 cycles, then m0_ready=1, m0_err=1, m0_rdata=0xFFFFFFFF; the next m0 read completes normally.
- mem_ready asserted on the exact cycle counter==TIMEOUT-1 with rdata 0x12345678 → m0_err=0, m0_rdata=0x12345678.
- reset asserted while BUSY → mem_valid=0 immediately; after release, prio=0 and a both-valid request grants m0.
